pixel_op_stream: RTL
====================

PIXEL_OP_STREAM -- requirements
Module: pixel_op_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, stream data width in bits; a multiple of PIX_WIDTH.
REQ-002 SHALL have parameter PIX_WIDTH, default 8, pixel width in bits; LANES = DATA_WIDTH/PIX_WIDTH.
REQ-003 SHALL have port axi_clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port axi_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port s_axis_valid  input  1  upstream beat valid.
REQ-006 SHALL have port s_axis_data  input  DATA_WIDTH  upstream pixels; lane i = bits [i*PIX_WIDTH +: PIX_WIDTH].
REQ-007 SHALL have port s_axis_last  input  1  last beat of frame.
REQ-008 SHALL have port s_axis_ready  output  1  block accepts a beat.
REQ-009 SHALL have port m_axis_valid  output  1  downstream beat valid.
REQ-010 SHALL have port m_axis_data  output  DATA_WIDTH  processed pixels.
REQ-011 SHALL have port m_axis_last  output  1  s_axis_last, delayed with its beat.
REQ-012 SHALL have port m_axis_ready  input  1  downstream accepts a beat.
REQ-013 SHALL have port cfg_mode  input  2  00 pass, 01 invert, 10 saturating add, 11 threshold.
REQ-014 SHALL have port cfg_param  input  PIX_WIDTH  offset (mode 10) or threshold (mode 11).
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse when a last beat leaves on m_axis.
REQ-016 SHALL have port frame_count  output  16  count of completed output frames; wraps 0xFFFF->0.

Function
REQ-017 Per lane p: pass -> p; invert -> (2^PIX_WIDTH-1)-p; add -> min(p+param, 2^PIX_WIDTH-1), computed PIX_WIDTH+1 wide; threshold -> p>=param ? all-ones : 0.
REQ-018 Transfer on a port occurs when valid and ready are both high at a rising edge.
REQ-019 Latency: a beat accepted at edge k SHALL be presented on m_axis at edge k (visible after it); empty pipe gives 1 cycle.
REQ-020 Output stage = output register plus one skid register; states EMPTY, ONE, FULL.
REQ-021 EMPTY: in-transfer -> ONE. ONE: in only -> FULL unless out; in+out -> ONE; out only -> EMPTY. FULL: out -> ONE (skid moves to output reg).
REQ-022 s_axis_ready SHALL be a register, high in EMPTY and ONE, low in FULL; no combinational path from m_axis_ready.
REQ-023 Sustained throughput SHALL be one beat per cycle with m_axis_ready held high.
REQ-024 m_axis_valid high with m_axis_ready low: m_axis_data/last SHALL hold stable.
REQ-025 Order SHALL be preserved; no beat dropped or duplicated.
REQ-026 cfg_mode/cfg_param SHALL be latched into shadow registers only at a frame boundary: at reset exit and on the cycle an input beat with s_axis_last is accepted; the latched values apply from the next accepted beat.
REQ-027 Config changes mid-frame SHALL not affect the current frame.
REQ-028 Processing SHALL occur at input acceptance; skid and output registers hold processed data.
REQ-029 frame_count increments on the same edge frame_done asserts.

Reset
REQ-030 On axi_reset_n low: state EMPTY, m_axis_valid 0, m_axis_data 0, m_axis_last 0, s_axis_ready 0, frame_done 0, frame_count 0, shadow config = pass/0.
REQ-031 First edge after reset release: s_axis_ready -> 1, shadow config loaded from cfg inputs.
REQ-032 Reset mid-frame SHALL discard all in-flight beats; next frame starts clean.

Structure
REQ-033 Mode encodings and state encoding SHALL live in shared package pixel_op_pkg.
REQ-034 Per-lane arithmetic SHALL be sub-module pixel_op_lane, instantiated LANES times via generate.

Verification
REQ-035 Invert, 8-bit: in 0x00FF807F, ready high -> out 0xFF007F80 one cycle later.
REQ-036 Add param 0x10: in 0xF5100000 -> out 0xFF201010 (saturation at lane 3).
REQ-037 Threshold param 0x80: in 0x807F00FF -> out 0xFF0000FF (equal maps to max).
REQ-038 Backpressure: 10 back-to-back beats, m_axis_ready low cycles 3-5 -> s_axis_ready low one cycle after FULL, all 10 beats out in order, data stable while stalled.
REQ-039 Config boundary: mode changed 01->00 mid-frame of 4 beats -> frame stays inverted; next frame passes; frame_done pulses once per frame, frame_count 1 then 2.
REQ-040 Reset asserted with FULL pipe -> m_axis_valid 0 immediately; prior beats never appear.

Source files
------------

// File: rtl/pixel_op_pkg.sv
// Shared encodings for the pixel operation stream: per-lane operation modes
// and the output-stage occupancy states.
package pixel_op_pkg;

    typedef enum logic [1:0] {
        ModePass   = 2'b00,
        ModeInvert = 2'b01,
        ModeAdd    = 2'b10,
        ModeThresh = 2'b11
    } pix_mode_e;

    // Output stage occupancy: output register only, or output plus skid register.
    localparam logic [1:0] StEmpty = 2'b00;
    localparam logic [1:0] StOne   = 2'b01;
    localparam logic [1:0] StFull  = 2'b10;

    localparam int unsigned FrameCountWidth = 16;

endpackage

// File: rtl/pixel_op_lane.sv
// Single-lane pixel operator: pass, invert, saturating add or threshold.
module pixel_op_lane
    import pixel_op_pkg::*;
#(
    parameter int unsigned PIX_WIDTH = 8
) (
    input  pix_mode_e              mode_i,
    input  logic [PIX_WIDTH-1:0]   param_i,
    input  logic [PIX_WIDTH-1:0]   pix_i,
    output logic [PIX_WIDTH-1:0]   pix_o
);

    localparam logic [PIX_WIDTH-1:0] PixMax = {PIX_WIDTH{1'b1}};

    logic [PIX_WIDTH:0] sum;

    always_comb begin
        // One extra bit so the carry out signals saturation.
        sum   = {1'b0, pix_i} + {1'b0, param_i};
        pix_o = pix_i;
        unique case (mode_i)
            ModePass:   pix_o = pix_i;
            ModeInvert: pix_o = PixMax - pix_i;
            ModeAdd:    pix_o = sum[PIX_WIDTH] ? PixMax : sum[PIX_WIDTH-1:0];
            ModeThresh: pix_o = (pix_i >= param_i) ? PixMax : '0;
        endcase
    end

endmodule

// File: rtl/pixel_op_stream.sv
// Streaming per-pixel operator with frame-aligned configuration shadowing and
// a two-entry (output + skid) registered output stage.
module pixel_op_stream
    import pixel_op_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PIX_WIDTH  = 8
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset_n,

    input  logic                  s_axis_valid,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_last,
    output logic                  s_axis_ready,

    output logic                  m_axis_valid,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_last,
    input  logic                  m_axis_ready,

    input  logic [1:0]            cfg_mode,
    input  logic [PIX_WIDTH-1:0]  cfg_param,

    output logic                  frame_done,
    output logic [15:0]           frame_count
);

    localparam int unsigned LANES = DATA_WIDTH / PIX_WIDTH;

    logic [1:0]                 state_q, state_d;
    logic                       ready_q, ready_d;
    logic                       init_q;
    pix_mode_e                  mode_q, mode_d;
    logic [PIX_WIDTH-1:0]       param_q, param_d;
    logic [DATA_WIDTH-1:0]      out_data_q, out_data_d;
    logic                       out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0]      skid_data_q, skid_data_d;
    logic                       skid_last_q, skid_last_d;
    logic                       done_q, done_d;
    logic [FrameCountWidth-1:0] count_q, count_d;

    logic                  in_fire;
    logic                  out_fire;
    logic [DATA_WIDTH-1:0] proc_data;

    assign m_axis_valid = (state_q != StEmpty);
    assign in_fire      = s_axis_valid & ready_q;
    assign out_fire     = m_axis_valid & m_axis_ready;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        pixel_op_lane #(
            .PIX_WIDTH (PIX_WIDTH)
        ) u_lane (
            .mode_i  (mode_q),
            .param_i (param_q),
            .pix_i   (s_axis_data[l*PIX_WIDTH +: PIX_WIDTH]),
            .pix_o   (proc_data[l*PIX_WIDTH +: PIX_WIDTH])
        );
    end

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;
        case (state_q)
            StEmpty: begin
                if (in_fire) begin
                    out_data_d = proc_data;
                    out_last_d = s_axis_last;
                    state_d    = StOne;
                end
            end
            StOne: begin
                if (in_fire && out_fire) begin
                    out_data_d = proc_data;
                    out_last_d = s_axis_last;
                end else if (in_fire) begin
                    skid_data_d = proc_data;
                    skid_last_d = s_axis_last;
                    state_d     = StFull;
                end else if (out_fire) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                // Input is blocked here since ready_q is low in this state.
                if (out_fire) begin
                    out_data_d = skid_data_q;
                    out_last_d = skid_last_q;
                    state_d    = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_comb begin
        ready_d = (state_d != StFull);
        mode_d  = mode_q;
        param_d = param_q;
        // The beat carrying last still uses the old shadow values.
        if (!init_q || (in_fire && s_axis_last)) begin
            mode_d  = pix_mode_e'(cfg_mode);
            param_d = cfg_param;
        end
        done_d  = out_fire & out_last_q;
        count_d = done_d ? count_q + 16'd1 : count_q;
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_q     <= StEmpty;
            ready_q     <= 1'b0;
            init_q      <= 1'b0;
            mode_q      <= ModePass;
            param_q     <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            skid_data_q <= '0;
            skid_last_q <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            init_q      <= 1'b1;
            mode_q      <= mode_d;
            param_q     <= param_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            skid_data_q <= skid_data_d;
            skid_last_q <= skid_last_d;
            done_q      <= done_d;
            count_q     <= count_d;
        end
    end

    assign s_axis_ready = ready_q;
    assign m_axis_data  = out_data_q;
    assign m_axis_last  = out_last_q;
    assign frame_done   = done_q;
    assign frame_count  = count_q;

endmodule
